// File: rtl/line_tracker_gen_if.sv
// line_tracker_gen_if: sensor, enable and status bundle between Core, tracker, Servo and Motor
interface line_tracker_gen_if #(
    parameter int N_IR    = 4,
    parameter int STEER_W = 3
);
    logic [N_IR-1:0]           ir;
    logic                      en_track;
    logic                      en_brake;
    logic signed [STEER_W-1:0] steer;
    logic [1:0]                motor;
    logic                      end_of_track;
    logic                      brake_done;
    logic                      fault;
    modport master (output ir, en_track, en_brake, input steer, motor, end_of_track, brake_done, fault);
    modport slave  (input ir, en_track, en_brake, output steer, motor, end_of_track, brake_done, fault);
endinterface

// File: rtl/line_tracker_gen.sv
// line_tracker_gen: debounced IR line follower with braking, end stop and lost-line handling (TRACK_LOST_RECOVERY_EN enables reverse-search recovery)
module line_tracker_gen #(
    parameter int N_IR       = 4,
    parameter int STEER_W    = 3,
    parameter int DEBOUNCE   = 1000,
    parameter int BRAKE_TIME = 500000,
    parameter int LOST_TIME  = 200000,
    parameter int CNT_W      = 20
) (
    input logic               clkus,
    input logic               rst,
    line_tracker_gen_if.slave bus
);
    localparam int SMAX = 2 ** (STEER_W - 1) - 1;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] BRK_LAST  = CNT_W'(BRAKE_TIME - 1);
    localparam logic [CNT_W-1:0] BRK_T     = CNT_W'(BRAKE_TIME);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_TIME - 1);
`ifdef TRACK_LOST_RECOVERY_EN
    localparam logic [CNT_W-1:0] LOSTX_LAST = CNT_W'(2 * LOST_TIME - 1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_TRACK, S_LOST, S_BRAKE, S_END} state_t;

    state_t                    st, st_n;
    logic [N_IR-1:0]           ir_s, ir_q;
    logic [CNT_W-1:0]          dcnt, tmr, tmr_n;
    logic                      lost_brk, lost_brk_n, done_brk;
    logic                      white, both_black;
    logic signed [STEER_W-1:0] raw, last_s, steer_n;
    logic [1:0]                motor_n;
    logic                      eot_n, bd_n, fault_n;
    int                        sum;

    assign white      = ~|ir_q;
    assign both_black = ir_q[N_IR-1] & ir_q[0];

    // sensor debounce: any change restarts the stability count, ir_q follows once stable
    always_ff @(posedge clkus or negedge rst)
        if (!rst) begin
            ir_s <= '0;
            ir_q <= '0;
            dcnt <= '0;
        end else if (bus.ir != ir_s) begin
            ir_s <= bus.ir;
            dcnt <= '0;
        end else if (dcnt >= DB_LAST)
            ir_q <= ir_s;
        else
            dcnt <= dcnt + 1'b1;

    // weighted steer: outer sensors pull hardest, left positive, right negative, saturated
    always_comb begin
        sum = 0;
        for (int i = 0; i < N_IR; i++)
            if (ir_q[i]) sum += (i >= N_IR / 2) ? (i - N_IR / 2 + 1) : -(N_IR / 2 - i);
        raw = sum > SMAX ? STEER_W'(SMAX) : sum < -SMAX ? STEER_W'(-SMAX) : STEER_W'(sum);
    end

    // next state, shared timer and next registered outputs
    always_comb begin
        st_n       = st;
        lost_brk_n = lost_brk;
        case (st)
            S_IDLE:
                if (bus.en_brake && !bus.brake_done) begin
                    st_n       = S_BRAKE;
                    lost_brk_n = 1'b0;
                end else if (bus.en_track && !bus.end_of_track && !bus.fault)
                    st_n = S_TRACK;
            S_TRACK:
                if (bus.en_brake && !bus.brake_done) begin
                    st_n       = S_BRAKE;
                    lost_brk_n = 1'b0;
                end else if (!bus.en_track)
                    st_n = S_IDLE;
                else if (both_black)
                    st_n = S_END;
                else if (white && tmr >= LOST_LAST) begin
`ifdef TRACK_LOST_RECOVERY_EN
                    st_n = S_LOST;
`else
                    st_n       = S_BRAKE;
                    lost_brk_n = 1'b1;
`endif
                end
`ifdef TRACK_LOST_RECOVERY_EN
            S_LOST:
                if (!white) st_n = S_TRACK;
                else if (tmr >= LOSTX_LAST) st_n = S_IDLE;
`endif
            S_BRAKE: if (tmr >= BRK_LAST) st_n = S_IDLE;
            S_END:   if (!bus.en_track) st_n = S_IDLE;
            default: st_n = S_IDLE;
        endcase
        tmr_n    = (st_n != st || (st == S_TRACK && !white)) ? '0 : tmr == '1 ? tmr : tmr + 1'b1;
        done_brk = st == S_BRAKE && st_n == S_IDLE;
        fault_n  = (bus.fault && bus.en_track) || (done_brk && lost_brk) || (st == S_LOST && st_n == S_IDLE);
        bd_n     = (bus.brake_done && bus.en_brake) || (done_brk && !lost_brk);
        eot_n    = st_n == S_END;
        motor_n  = st_n == S_TRACK ? 2'b01 :
                   st_n == S_LOST ? 2'b10 :
                   (st_n == S_BRAKE || (st_n == S_END && tmr_n < BRK_T)) ? 2'b11 : 2'b00;
        steer_n  = st_n == S_TRACK ? raw : st_n == S_LOST ? -last_s : '0;
    end

    // state, timer and output registers
    always_ff @(posedge clkus or negedge rst)
        if (!rst) begin
            st               <= S_IDLE;
            tmr              <= '0;
            lost_brk         <= 1'b0;
            last_s           <= '0;
            bus.steer        <= '0;
            bus.motor        <= 2'b00;
            bus.end_of_track <= 1'b0;
            bus.brake_done   <= 1'b0;
            bus.fault        <= 1'b0;
        end else begin
            st               <= st_n;
            tmr              <= tmr_n;
            lost_brk         <= lost_brk_n;
            if (st == S_TRACK && raw != '0) last_s <= raw;
            bus.steer        <= steer_n;
            bus.motor        <= motor_n;
            bus.end_of_track <= eot_n;
            bus.brake_done   <= bd_n;
            bus.fault        <= fault_n;
        end
endmodule

// File: tb/tb_line_tracker_gen.sv
// tb_line_tracker_gen: directed scenario bench for line_tracker_gen (N_IR=4, DEBOUNCE=2, BRAKE_TIME=5, LOST_TIME=4)
module tb_line_tracker_gen;
    logic clkus = 1'b0;
    logic rst   = 1'b0;
    int   vec   = 0;
    int   err   = 0;

    line_tracker_gen_if #(.N_IR(4), .STEER_W(3)) bus ();

    line_tracker_gen #(
        .N_IR(4), .STEER_W(3), .DEBOUNCE(2), .BRAKE_TIME(5), .LOST_TIME(4), .CNT_W(8)
    ) dut (
        .clkus(clkus),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clkus = ~clkus;

    task automatic cyc(input int n);
        repeat (n) @(negedge clkus);
    endtask

    task automatic test_reset;
        bus.ir = 4'b0000;
        bus.en_track = 1'b0;
        bus.en_brake = 1'b0;
        rst = 1'b0;
        cyc(3);
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL reset_motor: got %b exp 00", bus.motor); end
        vec++; if (bus.steer !== 3'sd0) begin err++; $display("FAIL reset_steer: got %0d exp 0", bus.steer); end
        vec++; if (bus.end_of_track !== 1'b0) begin err++; $display("FAIL reset_eot: got %b exp 0", bus.end_of_track); end
        vec++; if (bus.brake_done !== 1'b0) begin err++; $display("FAIL reset_brake_done: got %b exp 0", bus.brake_done); end
        vec++; if (bus.fault !== 1'b0) begin err++; $display("FAIL reset_fault: got %b exp 0", bus.fault); end
        rst = 1'b1;
        cyc(4);
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL idle_motor: got %b exp 00", bus.motor); end
    endtask

    task automatic test_track;
        bus.ir = 4'b0100;
        bus.en_track = 1'b1;
        cyc(1);
        vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL track_motor: got %b exp 01", bus.motor); end
        cyc(1);
        vec++; if (bus.steer !== 3'sd0) begin err++; $display("FAIL track_steer_early: got %0d exp 0", bus.steer); end
        cyc(2);
        vec++; if (bus.steer !== 3'sd1) begin err++; $display("FAIL track_steer: got %0d exp 1", bus.steer); end
    endtask

    task automatic test_steer;
        logic [3:0] pat [8] = '{4'b1000, 4'b0001, 4'b0110, 4'b1100, 4'b0011, 4'b1110, 4'b0111, 4'b0010};
        int exp_s [8] = '{2, -2, 0, 3, -3, 2, -2, -1};
        logic signed [2:0] e;
        for (int i = 0; i < 8; i++) begin
            bus.ir = pat[i];
            e = 3'(exp_s[i]);
            cyc(5);
            vec++; if (bus.steer !== e) begin err++; $display("FAIL steer_%b: got %0d exp %0d", pat[i], bus.steer, e); end
            vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL steer_motor_%b: got %b exp 01", pat[i], bus.motor); end
        end
    endtask

    task automatic test_debounce;
        for (int i = 0; i < 12; i++) begin
            bus.ir = i[0] ? 4'b0000 : 4'b0100;
            cyc(1);
            vec++; if (bus.steer !== -3'sd1) begin err++; $display("FAIL debounce_steer_%0d: got %0d exp -1", i, bus.steer); end
        end
        vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL debounce_motor: got %b exp 01", bus.motor); end
    endtask

    task automatic test_end;
        int n;
        bus.ir = 4'b1001;
        n = 0;
        while (bus.end_of_track !== 1'b1 && n < 10) begin cyc(1); n++; end
        vec++; if (bus.end_of_track !== 1'b1) begin err++; $display("FAIL end_entry: got %b exp 1", bus.end_of_track); end
        vec++; if (bus.motor !== 2'b11) begin err++; $display("FAIL end_brake_on: got %b exp 11", bus.motor); end
        n = 0;
        while (bus.motor == 2'b11 && n < 20) begin n++; cyc(1); end
        vec++; if (n != 5) begin err++; $display("FAIL end_brake_len: got %0d exp 5", n); end
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL end_motor_stop: got %b exp 00", bus.motor); end
        cyc(3);
        vec++; if (bus.end_of_track !== 1'b1) begin err++; $display("FAIL end_hold: got %b exp 1", bus.end_of_track); end
        bus.en_track = 1'b0;
        cyc(1);
        vec++; if (bus.end_of_track !== 1'b0) begin err++; $display("FAIL end_clear: got %b exp 0", bus.end_of_track); end
        bus.ir = 4'b0001;
        cyc(5);
    endtask

    task automatic test_lost;
        int n;
        bus.en_track = 1'b1;
        cyc(4);
        vec++; if (bus.steer !== -3'sd2) begin err++; $display("FAIL lost_pre_steer: got %0d exp -2", bus.steer); end
        bus.ir = 4'b0000;
`ifdef TRACK_LOST_RECOVERY_EN
        n = 0;
        while (bus.motor !== 2'b10 && n < 20) begin cyc(1); n++; end
        vec++; if (n != 7) begin err++; $display("FAIL lost_latency: got %0d exp 7", n); end
        vec++; if (bus.steer !== 3'sd2) begin err++; $display("FAIL lost_steer: got %0d exp 2", bus.steer); end
        bus.ir = 4'b0010;
        n = 0;
        while (bus.motor !== 2'b01 && n < 10) begin cyc(1); n++; end
        vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL reacquire_motor: got %b exp 01", bus.motor); end
        vec++; if (bus.steer !== -3'sd1) begin err++; $display("FAIL reacquire_steer: got %0d exp -1", bus.steer); end
        bus.ir = 4'b0000;
        n = 0;
        while (bus.motor !== 2'b10 && n < 20) begin cyc(1); n++; end
        vec++; if (bus.steer !== 3'sd1) begin err++; $display("FAIL lost2_steer: got %0d exp 1", bus.steer); end
        n = 0;
        while (bus.motor == 2'b10 && n < 20) begin n++; cyc(1); end
        vec++; if (n != 8) begin err++; $display("FAIL lost_timeout_len: got %0d exp 8", n); end
        vec++; if (bus.steer !== 3'sd0) begin err++; $display("FAIL fault_steer: got %0d exp 0", bus.steer); end
`else
        n = 0;
        while (bus.motor !== 2'b11 && n < 20) begin cyc(1); n++; end
        vec++; if (n != 7) begin err++; $display("FAIL lost_brake_latency: got %0d exp 7", n); end
        n = 0;
        while (bus.motor == 2'b11 && n < 20) begin n++; cyc(1); end
        vec++; if (n != 5) begin err++; $display("FAIL lost_brake_len: got %0d exp 5", n); end
        vec++; if (bus.brake_done !== 1'b0) begin err++; $display("FAIL lost_no_brake_done: got %b exp 0", bus.brake_done); end
`endif
        vec++; if (bus.fault !== 1'b1) begin err++; $display("FAIL fault_set: got %b exp 1", bus.fault); end
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL fault_motor: got %b exp 00", bus.motor); end
        cyc(3);
        vec++; if (bus.motor !== 2'b00 || bus.fault !== 1'b1) begin err++; $display("FAIL fault_hold: got motor %b fault %b exp 00 1", bus.motor, bus.fault); end
        bus.en_track = 1'b0;
        cyc(1);
        vec++; if (bus.fault !== 1'b0) begin err++; $display("FAIL fault_clear: got %b exp 0", bus.fault); end
    endtask

    task automatic test_brake;
        int n;
        bus.ir = 4'b0100;
        cyc(4);
        bus.en_track = 1'b1;
        cyc(5);
        vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL brake_pre_motor: got %b exp 01", bus.motor); end
        bus.en_brake = 1'b1;
        n = 0;
        cyc(1);
        while (bus.motor == 2'b11 && n < 20) begin n++; cyc(1); end
        vec++; if (n != 5) begin err++; $display("FAIL brake_len: got %0d exp 5", n); end
        vec++; if (bus.brake_done !== 1'b1) begin err++; $display("FAIL brake_done_set: got %b exp 1", bus.brake_done); end
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL brake_release: got %b exp 00", bus.motor); end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL no_rebrake_%0d: got %b exp 01", i, bus.motor); end
        end
        vec++; if (bus.brake_done !== 1'b1) begin err++; $display("FAIL brake_done_hold: got %b exp 1", bus.brake_done); end
        bus.en_brake = 1'b0;
        cyc(1);
        vec++; if (bus.brake_done !== 1'b0) begin err++; $display("FAIL brake_done_clear: got %b exp 0", bus.brake_done); end
    endtask

    task automatic test_reset_mid;
        bus.en_brake = 1'b1;
        cyc(2);
        vec++; if (bus.motor !== 2'b11) begin err++; $display("FAIL mid_brake_motor: got %b exp 11", bus.motor); end
        #2 rst = 1'b0;
        #1;
        vec++; if (bus.motor !== 2'b00) begin err++; $display("FAIL async_motor: got %b exp 00", bus.motor); end
        vec++; if (bus.steer !== 3'sd0) begin err++; $display("FAIL async_steer: got %0d exp 0", bus.steer); end
        vec++; if (bus.end_of_track !== 1'b0 || bus.brake_done !== 1'b0 || bus.fault !== 1'b0) begin
            err++; $display("FAIL async_flags: got eot %b bd %b fault %b exp 0 0 0", bus.end_of_track, bus.brake_done, bus.fault);
        end
        cyc(2);
        bus.en_brake = 1'b0;
        bus.en_track = 1'b0;
        #2 rst = 1'b1;
        cyc(2);
        vec++; if (bus.motor !== 2'b00 || bus.brake_done !== 1'b0) begin err++; $display("FAIL post_reset_idle: got motor %b bd %b exp 00 0", bus.motor, bus.brake_done); end
        bus.en_track = 1'b1;
        cyc(1);
        vec++; if (bus.motor !== 2'b01) begin err++; $display("FAIL post_reset_track: got %b exp 01", bus.motor); end
    endtask

    initial begin
        test_reset;
        test_track;
        test_steer;
        test_debounce;
        test_end;
        test_lost;
        test_brake;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
